// File: rtl/score_ctl.sv
// score_ctl: Pong score keeper. Watches the ball x position, turns each
// fresh arrival at a playfield edge into a point for the opposing player,
// and sequences the serve hold and game-over phases.
module score_ctl #(
    parameter int LEFT_EDGE   = 0,
    parameter int RIGHT_EDGE  = 1024,
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] xpos,
    input  logic        start,
    output logic [6:0]  points_first_player,
    output logic [6:0]  points_second_player,
    output logic        point_scored,
    output logic        serve_hold,
    output logic        game_over,
    output logic [1:0]  winner
);

    // Hold counter is loaded with HOLD_CYCLES-1, so clog2(HOLD_CYCLES) bits suffice.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [10:0]   LEFT_X    = 11'(LEFT_EDGE);
    localparam logic [10:0]   RIGHT_X   = 11'(RIGHT_EDGE);
    localparam logic [6:0]    WIN_P     = 7'(WIN_SCORE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   xpos_q;
    logic          at_left_q, at_right_q;
    logic [6:0]    p1_q, p1_d, p2_q, p2_d;
    logic [1:0]    winner_q, winner_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          point_q, point_d;
    logic          serve_hold_q, game_over_q;

    logic          at_left, at_right, miss_l, miss_r;
    logic [6:0]    p1_inc, p2_inc;

    // Edge flags from the registered position; a miss is a flag's rising edge,
    // so a ball parked at an edge scores only once.
    assign at_left  = (xpos_q <= LEFT_X);
    assign at_right = (xpos_q >= RIGHT_X);
    assign miss_l   = at_left  & ~at_left_q;
    assign miss_r   = at_right & ~at_right_q;
    assign p1_inc   = p1_q + 7'd1;
    assign p2_inc   = p2_q + 7'd1;

    // Next-state and score logic; left miss takes priority over right miss.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;
        hold_d   = hold_q;
        point_d  = 1'b0;
        if (start) begin
            // Start/restart from any state: fresh game, straight into play.
            p1_d     = 7'd0;
            p2_d     = 7'd0;
            winner_d = 2'b00;
            hold_d   = '0;
            state_d  = PLAY;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                PLAY: begin
                    if (miss_l) begin
                        p2_d    = p2_inc;
                        point_d = 1'b1;
                        if (p2_inc == WIN_P) begin
                            winner_d = 2'b10;
                            state_d  = OVER;
                        end else begin
                            hold_d  = HOLD_LOAD;
                            state_d = HOLD;
                        end
                    end else if (miss_r) begin
                        p1_d    = p1_inc;
                        point_d = 1'b1;
                        if (p1_inc == WIN_P) begin
                            winner_d = 2'b01;
                            state_d  = OVER;
                        end else begin
                            hold_d  = HOLD_LOAD;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d = PLAY;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                OVER: state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, score and output registers. Edge flags reset high so a ball
    // sitting at an edge right after reset does not score.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            xpos_q       <= 11'd0;
            at_left_q    <= 1'b1;
            at_right_q   <= 1'b1;
            p1_q         <= 7'd0;
            p2_q         <= 7'd0;
            winner_q     <= 2'b00;
            hold_q       <= '0;
            point_q      <= 1'b0;
            serve_hold_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            xpos_q       <= xpos;
            at_left_q    <= at_left;
            at_right_q   <= at_right;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            winner_q     <= winner_d;
            hold_q       <= hold_d;
            point_q      <= point_d;
            serve_hold_q <= (state_d != PLAY);
            game_over_q  <= (state_d == OVER);
        end
    end

    assign points_first_player  = p1_q;
    assign points_second_player = p2_q;
    assign point_scored         = point_q;
    assign serve_hold           = serve_hold_q;
    assign game_over            = game_over_q;
    assign winner               = winner_q;

endmodule

// File: tb/tb_score_ctl.sv
// tb_score_ctl: directed test of score_ctl with WIN_SCORE = 3 and
// HOLD_CYCLES = 10. Inputs change 1 ns after the rising edge and outputs
// are sampled at the same point, well away from the next edge.
module tb_score_ctl;

    logic        clk;
    logic        rst;
    logic [10:0] xpos;
    logic        start;
    logic [6:0]  points_first_player;
    logic [6:0]  points_second_player;
    logic        point_scored;
    logic        serve_hold;
    logic        game_over;
    logic [1:0]  winner;

    int n_cmp = 0;
    int n_err = 0;

    score_ctl #(
        .LEFT_EDGE   (0),
        .RIGHT_EDGE  (1024),
        .WIN_SCORE   (3),
        .HOLD_CYCLES (10)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .xpos                 (xpos),
        .start                (start),
        .points_first_player  (points_first_player),
        .points_second_player (points_second_player),
        .point_scored         (point_scored),
        .serve_hold           (serve_hold),
        .game_over            (game_over),
        .winner               (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: one line per transaction.
    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_scores(input string tag, input int p1, input int p2);
        check({tag, ".p1"}, int'(points_first_player), p1);
        check({tag, ".p2"}, int'(points_second_player), p2);
    endtask

    // Move the ball off the edge, then onto one edge; the point (if any)
    // lands two edges after xpos first reaches the edge.
    task automatic miss(input string tag, input bit right, input bit exp_pt);
        xpos = 11'd500;
        repeat (3) step();
        xpos = right ? 11'd1024 : 11'd0;
        step();
        check({tag, ".pulse_early"}, int'(point_scored), 0);
        step();
        check({tag, ".pulse"}, int'(point_scored), int'(exp_pt));
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin : stim
        int hi;
        int pulses;

        rst   = 1'b0;
        xpos  = 11'd0;
        start = 1'b0;

        // Reset held for three cycles.
        repeat (3) step();
        check_scores("rst", 0, 0);
        check("rst.serve_hold", int'(serve_hold), 1);
        check("rst.winner", int'(winner), 0);
        check("rst.game_over", int'(game_over), 0);
        rst = 1'b1;
        pulses = 0;
        repeat (5) begin
            step();
            pulses += int'(point_scored);
        end
        check("rst.no_pulse", pulses, 0);
        check("idle.serve_hold", int'(serve_hold), 1);

        // Start: PLAY with scores cleared one cycle later.
        start_pulse();
        check_scores("start", 0, 0);
        check("start.serve_hold", int'(serve_hold), 0);

        // Single right miss with a 500 -> 1024 sweep, then park at 1024.
        xpos = 11'd500;  step();
        xpos = 11'd700;  step();
        xpos = 11'd900;  step();
        xpos = 11'd1023; step();
        check("sweep.no_pulse", int'(point_scored), 0);
        xpos = 11'd1024;
        step();
        check("single.pulse_early", int'(point_scored), 0);
        step();
        check("single.pulse", int'(point_scored), 1);
        check_scores("single", 1, 0);
        hi = int'(serve_hold);
        pulses = 1;
        repeat (19) begin
            step();
            hi += int'(serve_hold);
            pulses += int'(point_scored);
        end
        check("single.hold_len", hi, 10);
        check("single.pulses", pulses, 1);
        check("single.hold_end", int'(serve_hold), 0);

        // Left miss: second player gains exactly one.
        miss("left", 1'b0, 1'b1);
        check_scores("left", 1, 1);

        // Edge touches during HOLD are ignored.
        pulses = 0;
        xpos = 11'd1024; step(); pulses += int'(point_scored);
        xpos = 11'd0;    step(); pulses += int'(point_scored);
        xpos = 11'd1024; step(); pulses += int'(point_scored);
        check("hold.still_hold", int'(serve_hold), 1);
        repeat (9) begin
            step();
            pulses += int'(point_scored);
        end
        check("hold.pulses", pulses, 0);
        check_scores("hold", 1, 1);
        check("hold.back_play", int'(serve_hold), 0);

        // Win for the first player at 3.
        miss("r2", 1'b1, 1'b1);
        check_scores("r2", 2, 1);
        repeat (12) step();
        miss("r3", 1'b1, 1'b1);
        check_scores("win", 3, 1);
        check("win.winner", int'(winner), 1);
        check("win.game_over", int'(game_over), 1);
        check("win.serve_hold", int'(serve_hold), 1);
        repeat (15) step();
        check("over.serve_hold", int'(serve_hold), 1);
        miss("over", 1'b1, 1'b0);
        check_scores("over", 3, 1);
        check("over.winner", int'(winner), 1);

        // New game from OVER goes straight to PLAY.
        start_pulse();
        check_scores("restart", 0, 0);
        check("restart.winner", int'(winner), 0);
        check("restart.game_over", int'(game_over), 0);
        check("restart.serve_hold", int'(serve_hold), 0);

        // Build 2/1, then reset asynchronously in the middle of HOLD.
        miss("m1", 1'b1, 1'b1);
        repeat (12) step();
        miss("m2", 1'b1, 1'b1);
        repeat (12) step();
        miss("m3", 1'b0, 1'b1);
        check_scores("prerst", 2, 1);
        step();
        check("prerst.hold", int'(serve_hold), 1);
        rst = 1'b0;
        #2;
        check_scores("arst", 0, 0);
        check("arst.serve_hold", int'(serve_hold), 1);
        check("arst.winner", int'(winner), 0);
        check("arst.game_over", int'(game_over), 0);
        check("arst.pulse", int'(point_scored), 0);
        step();
        step();
        rst = 1'b1;
        repeat (3) step();
        check("post.idle", int'(serve_hold), 1);
        miss("idle", 1'b1, 1'b0);
        check_scores("idle", 0, 0);
        check("idle.still", int'(serve_hold), 1);
        start_pulse();
        check("post.play", int'(serve_hold), 0);
        check_scores("post", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_ctl.md
# score_ctl

Score keeper for the Pong datapath, sitting on the output side of `ball_ctl`. It consumes the ball position `ball_ctl` produces, detects each miss at the left or right playfield edge, and counts points per player. It drives the `points_first_player` / `points_second_player` buses back into `ball_ctl`, and sequences the serve hold and game-over phase.

## Interface
- `LEFT_EDGE`, default 0: an xpos at or below this value is a miss on the left; the second player scores.
- `RIGHT_EDGE`, default 1024: an xpos at or above this value is a miss on the right; the first player scores.
- `WIN_SCORE`, default 11: first player to reach this score wins. Legal range 1..99.
- `HOLD_CYCLES`, default 50_000_000: length of the serve-hold window after each point, in clk cycles. Minimum 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `xpos`  in  11  ball x position from `ball_ctl`.
- `start`  in  1  one-cycle start/restart request (debounced upstream).
- `points_first_player`  out  7  first-player score, unsigned.
- `points_second_player`  out  7  second-player score, unsigned.
- `point_scored`  out  1  one-cycle pulse in the cycle a score register updates.
- `serve_hold`  out  1  high while the ball must stay frozen (IDLE, HOLD, OVER).
- `game_over`  out  1  high in OVER.
- `winner`  out  2  00 = none, 01 = first player, 10 = second player.

## Operation
- Edge flags, computed from the registered copy `xpos_q`:
  - `at_left = (xpos_q <= LEFT_EDGE)`
  - `at_right = (xpos_q >= RIGHT_EDGE)`
  - The previous-cycle flags `at_left_q` / `at_right_q` are also registered.
- A miss event is a rising edge of a flag:
  - `miss_l = at_left & ~at_left_q`
  - `miss_r = at_right & ~at_right_q`
  - A ball resting at an edge therefore scores exactly once.
- FSM states: IDLE, PLAY, HOLD, OVER.
  - IDLE: scores held. On `start`, clear both scores, clear `winner`, go to PLAY.
  - PLAY, on `miss_l`: increment `points_second_player` and pulse `point_scored`.
    - If the new value equals WIN_SCORE, set `winner` = 10 and go to OVER.
    - Otherwise load the hold counter with HOLD_CYCLES-1 and go to HOLD.
  - PLAY, on `miss_r`: same, but increment `points_first_player` and set `winner` = 01 on a win.
  - HOLD: the counter decrements every cycle. At 0, return to PLAY.
  - OVER: scores and `winner` frozen. On `start`, clear scores and `winner`, go to PLAY (new game, no hold).
- Simultaneous `miss_l` and `miss_r` (only possible with misconfigured edges): `miss_l` wins and `miss_r` is dropped.
- Misses in IDLE, HOLD and OVER are ignored. The flag registers still track, so a ball left sitting at an edge does not score on re-entry to PLAY.
- `start` in PLAY or HOLD restarts: clear scores, clear `winner`, go to PLAY, cancel the hold counter.
- Score arithmetic:
  - 7-bit unsigned, incremented only in PLAY.
  - Cannot exceed WIN_SCORE (≤ 99), so no wrap is possible.
  - The counter clears only on `start` or `rst`.

## Timing
- Reset (`rst` low, asynchronous) sets:
  - state = IDLE, both scores = 0, `point_scored` = 0, `winner` = 00, `game_over` = 0
  - `serve_hold` = 1, `xpos_q` = 0, hold counter = 0
  - Both edge flag registers = 1, which suppresses a spurious score right after reset.
- Release of `rst` takes effect on the next rising clk edge. A reset asserted mid-game clears everything immediately, without waiting for a clock.
- Miss latency: xpos reaches the edge in cycle N and is sampled into `xpos_q` at edge N+1. The flags register at edge N+2, and at that same edge the score register, `point_scored`, state, `winner` and `game_over` all update.
- All outputs are registered; none depend combinationally on inputs.
- `serve_hold` is decoded from the registered state:
  - high from the cycle after a point for exactly HOLD_CYCLES cycles, then low
  - stays high continuously if the game ends
- `start` latency: one cycle from sample to PLAY with scores = 0.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with `xpos` = 0 → scores 0/0, `serve_hold` = 1, `winner` = 00. Release and keep `xpos` = 0 → no `point_scored` pulse.
- **Single point:**
  - Setup: `start` pulse, then `xpos` sweeps 500 → 1024 and holds at 1024 for 20 cycles.
  - Required: `points_first_player` = 1, exactly one `point_scored` pulse 2 cycles after `xpos` first equals 1024.
  - Required: `serve_hold` high for exactly HOLD_CYCLES (bench sets HOLD_CYCLES = 10), then low.
- **Ignored misses in HOLD:** during the hold window, move `xpos` 1024 → 0 → 1024 → both scores unchanged.
- **Left miss:** `xpos` goes to 0 in PLAY → `points_second_player` increments by exactly 1.
- **Win:** WIN_SCORE = 3, drive three right misses (each after the hold expires).
  - Required: score reaches 3, `winner` = 01, `game_over` = 1, `serve_hold` stays 1.
  - A further miss does not change the score.
  - `start` → scores 0/0, `winner` = 00, PLAY on the next cycle.
- **Reset mid-hold:** assert `rst` in the HOLD cycle (score 2/1) → outputs reach reset values without a clock edge. After release, the FSM stays in IDLE until `start`.
